adc_serial_reader: RTL
======================

Name: adc_serial_reader

Overview:
- clk-domain master for the external serial ADC that runs on its own asynchronous ~33 MHz clock.
- Issues a conversion request on adc_nconv, then waits for the ADC's BUSY frame.
- Deserialises the 16-bit MSB-first word the ADC clocks out on its own SCLK/SDOUT, and presents it with a one-cycle valid strobe.
- Sits between the ADC pins and downstream sample processing.

Parameters:
- DATA_W, 16, bits per ADC frame.
- SYNC_STAGES, 2, flip-flop stages on each asynchronous ADC input (min 2).
- TIMEOUT, 4096, max clk cycles allowed in CONV or SHIFT before the frame is aborted.
- CNT_W, 13, timeout counter width; must hold TIMEOUT.

Ports:
- clk  in  1  system clock (200 MHz nominal).
- nrst  in  1  asynchronous active-low reset.
- start  in  1  conversion request, one-cycle pulse; honoured only in IDLE.
- adc_nconv  out  1  ADC convert request, active low.
- adc_busy  in  1  ADC busy, asynchronous to clk.
- adc_sclk  in  1  ADC serial clock, asynchronous to clk.
- adc_sdout  in  1  ADC serial data, asynchronous to clk.
- data_out  out  DATA_W  last good word, held until the next good frame.
- data_valid  out  1  one-cycle strobe, data_out updated.
- frame_err  out  1  one-cycle strobe, frame ended with bit count != DATA_W.
- timeout_err  out  1  one-cycle strobe, frame aborted by timeout.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (nrst low, async assert): adc_nconv=1, data_out=0, data_valid=0, frame_err=0, timeout_err=0, busy=0, state=IDLE, synchronisers=0.
  - Reset mid-frame aborts it silently, with no error strobe.
- Input conditioning:
  - adc_busy, adc_sclk and adc_sdout each pass through SYNC_STAGES flops.
  - sclk_rise is asserted when the synchronised sclk is 1 and its previous value was 0.
  - busy_rise and busy_fall are derived the same way from synchronised busy.
  - sdout is sampled from the same synchroniser stage as sclk.
  - Valid only while clk >= 4x adc_sclk frequency.
- ADC protocol:
  - The ADC raises BUSY with bit[DATA_W-1] already on SDOUT.
  - SDOUT changes only on SCLK falling edges.
  - Each bit is therefore sampled on an SCLK rising edge.
  - 2*DATA_W SCLK toggles, then BUSY falls.
- State machine:
  - IDLE: adc_nconv=1. When start=1, go to CONV and clear the timeout counter. Stay in IDLE if busy_s=1, i.e. the ADC is still finishing a frame.
  - CONV: adc_nconv=0. On busy_rise, set adc_nconv=1, clear bit_cnt and the shift register, and go to SHIFT. On counter==TIMEOUT-1, pulse timeout_err and go to IDLE.
  - SHIFT: on each sclk_rise, shift the register left, insert sdout_s at the LSB, and increment bit_cnt (saturating at DATA_W+1). On busy_fall go to DONE. On counter==TIMEOUT-1, pulse timeout_err and go to IDLE.
  - DONE (1 cycle): if bit_cnt==DATA_W, load data_out from the shift register and pulse data_valid. Otherwise pulse frame_err and leave data_out unchanged. Then go to IDLE.
- Simultaneous events:
  - sclk_rise and busy_fall in the same cycle: the bit is shifted, then the state moves to DONE.
  - start outside IDLE is dropped; there is no queueing.
- Latency:
  - data_valid rises SYNC_STAGES+2 clk cycles after adc_busy falls.
  - adc_nconv rises SYNC_STAGES+1 clk cycles after adc_busy rises.
- Bits beyond DATA_W still shift in; the saturated count forces frame_err.
- All outputs are registered.

Decomposition:
- Package adc_reader_pkg holds:
  - the state enum (IDLE, CONV, SHIFT, DONE);
  - a localparam for the default DATA_W;
  - a function returning the width for a TIMEOUT value.
- Sub-module adc_in_sync: a SYNC_STAGES-deep synchroniser plus rise/fall detector.
  - Instantiated three times, for busy, sclk and sdout.
  - The sdout instance uses only its level output.

Test Plan:
- Nominal frame: clk 200 MHz, ADC model on 33 MHz sending 16'hACCF, start pulse → adc_nconv low until BUSY seen; data_out=16'hACCF, data_valid exactly one cycle, frame_err=0.
- Back-to-back: start issued every time busy drops, words 16'h0001, 16'hFFFF, 16'h8000 → three data_valid strobes with those values in order, no errors.
- Short frame: model drops BUSY after 15 SCLK rises → frame_err one cycle, data_out keeps the previous value, data_valid stays 0.
- No response: BUSY never rises, TIMEOUT=4096 → timeout_err on cycle 4096 after start, adc_nconv=1, busy=0.
- Reset mid-SHIFT: nrst low after 8 bits → all outputs at reset values immediately; next full frame 16'h5A5A is read correctly.
- start while busy=1, and a start held for 2 cycles → exactly one conversion per accepted start, no extra adc_nconv pulse.

Source files
------------

// File: rtl/adc_reader_pkg.sv
// ---------------------------------------------------------------------------
// adc_reader_pkg
//   Shared definitions for the serial ADC reader:
//     - state_t          : reader state machine encoding
//     - DEFAULT_DATA_W   : default ADC frame width in bits
//     - cnt_width()      : counter width able to hold a given TIMEOUT value
// ---------------------------------------------------------------------------
package adc_reader_pkg;

    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Smallest width that can represent the value 'timeout' itself.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/adc_serial_reader_if.sv
// ---------------------------------------------------------------------------
// adc_serial_reader_if
//   Bundles the ADC pin signals and the downstream sample interface.
//   Ports (signals):
//     start        conversion request pulse (to reader)
//     adc_nconv    ADC convert request, active low (from reader)
//     adc_busy     ADC BUSY, asynchronous (to reader)
//     adc_sclk     ADC serial clock, asynchronous (to reader)
//     adc_sdout    ADC serial data, asynchronous (to reader)
//     data_out     last good word (from reader)
//     data_valid   one-cycle strobe, data_out updated (from reader)
//     frame_err    one-cycle strobe, wrong bit count (from reader)
//     timeout_err  one-cycle strobe, frame aborted (from reader)
//     busy         reader not idle (from reader)
//   Modports: master = the reader, slave = ADC/control side.
// ---------------------------------------------------------------------------
interface adc_serial_reader_if
    import adc_reader_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic              start;
    logic              adc_nconv;
    logic              adc_busy;
    logic              adc_sclk;
    logic              adc_sdout;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              frame_err;
    logic              timeout_err;
    logic              busy;

    modport master (
        input  start, adc_busy, adc_sclk, adc_sdout,
        output adc_nconv, data_out, data_valid, frame_err, timeout_err, busy
    );

    modport slave (
        output start, adc_busy, adc_sclk, adc_sdout,
        input  adc_nconv, data_out, data_valid, frame_err, timeout_err, busy
    );
endinterface

// File: rtl/adc_in_sync.sv
// ---------------------------------------------------------------------------
// adc_in_sync
//   SYNC_STAGES-deep synchroniser for one asynchronous input, followed by a
//   rise/fall detector on the synchronised level.
//   Ports:
//     clk      system clock
//     nrst     asynchronous active-low reset (clears all stages)
//     async_i  asynchronous input
//     level_o  synchronised level
//     rise_o   level is 1 and was 0 on the previous cycle
//     fall_o   level is 0 and was 1 on the previous cycle
//   SYNC_STAGES must be at least 2.
// ---------------------------------------------------------------------------
module adc_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;

    // Stage 0 takes the raw input; each later stage takes its predecessor.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign sync_d[gi] = async_i;
            end else begin : g_next
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  =  level_o & ~prev_q;
    assign fall_o  = ~level_o &  prev_q;

endmodule

// File: rtl/adc_serial_reader.sv
// ---------------------------------------------------------------------------
// adc_serial_reader
//   Requests a conversion from an external serial ADC, waits for its BUSY
//   frame, deserialises the MSB-first word clocked out on the ADC's own
//   SCLK/SDOUT and presents it with a one-cycle valid strobe.
//   Ports:
//     clk    system clock
//     nrst   asynchronous active-low reset
//     bus    adc_serial_reader_if.master (ADC pins + sample output)
//   All outputs are registered.
// ---------------------------------------------------------------------------
module adc_serial_reader
    import adc_reader_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 4096,
    parameter int CNT_W       = cnt_width(TIMEOUT)
) (
    input  logic                  clk,
    input  logic                  nrst,
    adc_serial_reader_if.master   bus
);

    // Bit counter saturates at DATA_W+1 so an over-long frame stays wrong.
    localparam int                   BIT_CNT_W = $clog2(DATA_W + 2);
    localparam logic [BIT_CNT_W-1:0] BIT_FULL  = BIT_CNT_W'(DATA_W);
    localparam logic [BIT_CNT_W-1:0] BIT_SAT   = BIT_CNT_W'(DATA_W + 1);
    localparam logic [CNT_W-1:0]     TMO_LAST  = CNT_W'(TIMEOUT - 1);

    // ---------------- input conditioning ----------------
    logic busy_s, busy_rise, busy_fall;
    logic sclk_s, sclk_rise, sclk_fall_unused;
    logic sdout_s, sdout_rise_unused, sdout_fall_unused;

    adc_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_busy (
        .clk     (clk),
        .nrst    (nrst),
        .async_i (bus.adc_busy),
        .level_o (busy_s),
        .rise_o  (busy_rise),
        .fall_o  (busy_fall)
    );

    adc_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk     (clk),
        .nrst    (nrst),
        .async_i (bus.adc_sclk),
        .level_o (sclk_s),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall_unused)
    );

    // Same depth as the sclk path, so data is taken from the same stage
    // that reports the SCLK rising edge.
    adc_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdout (
        .clk     (clk),
        .nrst    (nrst),
        .async_i (bus.adc_sdout),
        .level_o (sdout_s),
        .rise_o  (sdout_rise_unused),
        .fall_o  (sdout_fall_unused)
    );

    // ---------------- state and datapath registers ----------------
    state_t                state_q,   state_d;
    logic [CNT_W-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]     shift_q,   shift_d;
    logic [DATA_W-1:0]     data_q,    data_d;
    logic                  nconv_q,   nconv_d;
    logic                  valid_q,   valid_d;
    logic                  ferr_q,    ferr_d;
    logic                  terr_q,    terr_d;
    logic                  busy_q,    busy_d;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            tmo_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            nconv_q   <= 1'b1;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            terr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            nconv_q   <= nconv_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            terr_q    <= terr_d;
            busy_q    <= busy_d;
        end
    end

    // ---------------- next-state / output logic ----------------
    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        nconv_d   = nconv_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        terr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                nconv_d = 1'b1;
                // A still-busy ADC is finishing an earlier frame; a new
                // request now would be misread, so the start is dropped.
                if (bus.start && !busy_s) begin
                    state_d   = CONV;
                    tmo_cnt_d = '0;
                    nconv_d   = 1'b0;
                end
            end

            CONV: begin
                nconv_d   = 1'b0;
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (busy_rise) begin
                    nconv_d   = 1'b1;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    state_d   = SHIFT;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    nconv_d = 1'b1;
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            SHIFT: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                // Shift first so a last bit coinciding with BUSY falling
                // is still captured.
                if (sclk_rise) begin
                    shift_d = {shift_q[DATA_W-2:0], sdout_s};
                    if (bit_cnt_q != BIT_SAT) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                if (busy_fall) begin
                    state_d = DONE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            DONE: begin
                if (bit_cnt_q == BIT_FULL) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                end else begin
                    ferr_d = 1'b1;
                end
                state_d = IDLE;
            end

            default: begin
                nconv_d = 1'b1;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // sclk level itself is not needed beyond edge detection.
    logic sclk_level_unused;
    assign sclk_level_unused = sclk_s;

    assign bus.adc_nconv   = nconv_q;
    assign bus.data_out    = data_q;
    assign bus.data_valid  = valid_q;
    assign bus.frame_err   = ferr_q;
    assign bus.timeout_err = terr_q;
    assign bus.busy        = busy_q;

endmodule
